// File: rtl/flag_sequencer.sv
// Flag selector sequencer: debounced next/prev buttons plus auto-advance, stepping
// an 8-bit selector with wrap-around and committing changes only on frame_start.
module flag_sequencer #(
  parameter int DEBOUNCE_BITS   = 18,
  parameter int FRAMES_PER_FLAG = 180,
  parameter int FRAME_CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  input  logic [7:0] count,
  output logic [7:0] selector,
  output logic       changed
);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_NEXT = 2'd1,
    PEND_PREV = 2'd2
  } pend_e;

  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX     = '1;
  localparam logic [FRAME_CNT_W-1:0]   FRAME_LAST = FRAME_CNT_W'(FRAMES_PER_FLAG - 1);

  // Bit 0 carries the next button, bit 1 the prev button.
  logic [1:0]               sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, press_s;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q [2];
  logic [DEBOUNCE_BITS-1:0] db_cnt_d [2];

  pend_e                    pend_q, pend_d;
  logic [7:0]               selector_q, selector_d, step_next_s, step_prev_s;
  logic                     changed_q, changed_d;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  always_comb begin
    sync1_d  = {btn_prev, btn_next};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_s  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
          press_s[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DEBOUNCE_BITS'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  assign step_next_s = (selector_q == count - 8'd1) ? 8'd0 : selector_q + 8'd1;
  assign step_prev_s = (selector_q == 8'd0) ? count - 8'd1 : selector_q - 8'd1;

  always_comb begin
    selector_d  = selector_q;
    changed_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    pend_d      = pend_q;
    if (frame_start) begin
      if (count == 8'd0) begin
        selector_d  = 8'd0;
        changed_d   = (selector_q != 8'd0);
        frame_cnt_d = '0;
        pend_d      = PEND_NONE;
      end else if (selector_q >= count) begin
        selector_d  = 8'd0;
        changed_d   = 1'b1;
        frame_cnt_d = '0;
        pend_d      = PEND_NONE;
      end else if (pend_q != PEND_NONE) begin
        selector_d  = (pend_q == PEND_NEXT) ? step_next_s : step_prev_s;
        changed_d   = 1'b1;
        frame_cnt_d = '0;
        pend_d      = PEND_NONE;
      end else if (auto_en && (frame_cnt_q == FRAME_LAST)) begin
        selector_d  = step_next_s;
        changed_d   = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = auto_en ? frame_cnt_q + FRAME_CNT_W'(1) : '0;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    // A press landing on a commit cycle is kept for the following frame.
    case (press_s)
      2'b01:   pend_d = PEND_NEXT;
      2'b10:   pend_d = PEND_PREV;
      default: pend_d = pend_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      stable_q    <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      pend_q      <= PEND_NONE;
      selector_q  <= 8'd0;
      changed_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      pend_q      <= pend_d;
      selector_q  <= selector_d;
      changed_q   <= changed_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign selector = selector_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer: a vector table of button/count scenarios plus
// hand-written sequences for reset, auto-advance and same-cycle press timing.
module tb_flag_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] count = 8'd25;
  logic [7:0] selector;
  logic       changed;

  int n_vec  = 0;
  int n_miss = 0;

  flag_sequencer #(
    .DEBOUNCE_BITS  (2),
    .FRAMES_PER_FLAG(3),
    .FRAME_CNT_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .auto_en    (auto_en),
    .count      (count),
    .selector   (selector),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // btn: 0 none, 1 next, 2 prev, 3 next then prev, 4 bouncing next
  typedef struct {
    int         btn;
    logic [7:0] cnt;
    logic [7:0] exp_sel;
    logic       exp_ch;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_next = 1'b1; else btn_prev = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (10) tick();
  endtask

  task automatic bounce();
    for (int k = 0; k < 6; k++) begin
      btn_next = ~btn_next;
      tick();
    end
    btn_next = 1'b0;
    repeat (10) tick();
  endtask

  task automatic frame(input string name, input logic [7:0] exp_sel, input logic exp_ch);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({name, " sel"}, selector, exp_sel);
    check({name, " chg"}, {7'd0, changed}, {7'd0, exp_ch});
    tick();
    check({name, " chg_off"}, {7'd0, changed}, 8'd0);
    repeat (3) tick();
  endtask

  vec_t       vecs [14];
  logic [7:0] prev_sel;
  logic [7:0] auto_sel [7];
  logic       auto_ch  [7];
  logic [7:0] rs_sel   [7];
  logic       rs_ch    [7];

  initial begin
    vecs[0]  = '{2, 8'd25, 8'd24, 1'b1};
    vecs[1]  = '{1, 8'd25, 8'd0,  1'b1};
    vecs[2]  = '{1, 8'd25, 8'd1,  1'b1};
    vecs[3]  = '{0, 8'd25, 8'd1,  1'b0};
    vecs[4]  = '{3, 8'd25, 8'd0,  1'b1};
    vecs[5]  = '{2, 8'd25, 8'd24, 1'b1};
    vecs[6]  = '{4, 8'd25, 8'd24, 1'b0};
    vecs[7]  = '{0, 8'd8,  8'd0,  1'b1};
    vecs[8]  = '{2, 8'd8,  8'd7,  1'b1};
    vecs[9]  = '{1, 8'd8,  8'd0,  1'b1};
    vecs[10] = '{1, 8'd8,  8'd1,  1'b1};
    vecs[11] = '{0, 8'd0,  8'd0,  1'b1};
    vecs[12] = '{1, 8'd0,  8'd0,  1'b0};
    vecs[13] = '{0, 8'd0,  8'd0,  1'b0};
    auto_sel = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
    auto_ch  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rs_sel   = '{8'd2, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd5};
    rs_ch    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state and idle frames
    repeat (3) tick();
    check("rst sel", selector, 8'd0);
    check("rst chg", {7'd0, changed}, 8'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      repeat (16) tick();
      frame("idle", 8'd0, 1'b0);
    end

    // Clean press: nothing moves until frame_start
    press(0);
    check("pre-frame hold", selector, 8'd0);
    frame("next", 8'd1, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      press(0);
      frame("climb", 8'(k), 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("async rst sel", selector, 8'd0);
    check("async rst chg", {7'd0, changed}, 8'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    prev_sel = 8'd0;
    for (int v = 0; v < 14; v++) begin
      count = vecs[v].cnt;
      tick();
      case (vecs[v].btn)
        1:       press(0);
        2:       press(1);
        3:       begin press(0); press(1); end
        4:       bounce();
        default: repeat (5) tick();
      endcase
      check($sformatf("v%0d hold", v), selector, prev_sel);
      frame($sformatf("v%0d", v), vecs[v].exp_sel, vecs[v].exp_ch);
      prev_sel = vecs[v].exp_sel;
    end

    // Auto-advance every third frame
    count = 8'd25;
    auto_en = 1'b1;
    for (int k = 0; k < 7; k++) frame($sformatf("auto%0d", k + 1), auto_sel[k], auto_ch[k]);

    // Clear the frame counter, then check a press restarts the hold
    auto_en = 1'b0;
    frame("auto off", 8'd2, 1'b0);
    auto_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) press(0);
      frame($sformatf("restart%0d", k + 1), rs_sel[k], rs_ch[k]);
    end

    // Press event coinciding with frame_start is deferred one frame
    auto_en = 1'b0;
    frame("auto off2", 8'd5, 1'b0);
    btn_next = 1'b1;
    repeat (5) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("same-cycle sel", selector, 8'd5);
    check("same-cycle chg", {7'd0, changed}, 8'd0);
    repeat (5) tick();
    btn_next = 1'b0;
    repeat (10) tick();
    frame("deferred", 8'd6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
